// File: rtl/arbiter_rr16.sv
// arbiter_rr16: 16-way round-robin arbiter with hold timeout; optional ARB_BACK_TO_BACK_EN removes the idle bubble between grants.

// decoder4_16: one-hot decode of a 4-bit index, all zeros when disabled.
module decoder4_16 (
   input  logic [3:0]  idx,
   input  logic        en,
   output logic [15:0] y
);
   assign y = en ? 16'(1) << idx : 16'h0000;
endmodule

module arbiter_rr16 #(
   parameter int MAX_HOLD = 8
) (
   input  logic        I_CLK,
   input  logic        I_RESET,
   input  logic [15:0] I_REQ,
   input  logic        I_RELEASE,
   output logic [15:0] O_GRANT,
   output logic [3:0]  O_GRANT_IDX,
   output logic        O_GRANT_VALID,
   output logic        O_TIMEOUT
);
   typedef enum logic {IDLE, GRANTED} state_t;

   localparam logic       HOLD_EN   = MAX_HOLD != 0;
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state, state_n;
   logic [3:0] ptr, ptr_n, idx_n;
   logic [7:0] cnt, cnt_n;
   logic       to_n, rel_a, rel_b, rel_c, rel;

   // First set bit of r searching p, p+1, ... with mod-16 wrap; lowest offset wins.
   function automatic logic [3:0] pick(input logic [15:0] r, input logic [3:0] p);
      logic [3:0] j;
      pick = p;
      for (int i = 15; i >= 0; i--) begin
         j = p + 4'(i);
         if (r[j]) pick = j;
      end
   endfunction

   assign rel_a = I_RELEASE;
   assign rel_b = !I_REQ[O_GRANT_IDX];
   assign rel_c = HOLD_EN && cnt == HOLD_LAST;
   assign rel   = rel_a || rel_b || rel_c;

   // Next-state: arbitrate in IDLE, hold or release in GRANTED.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      idx_n   = O_GRANT_IDX;
      cnt_n   = cnt;
      to_n    = 1'b0;
      if (state == IDLE) begin
         state_n = |I_REQ ? GRANTED : IDLE;
         idx_n   = |I_REQ ? pick(I_REQ, ptr) : O_GRANT_IDX;
         cnt_n   = 8'd0;
      end else if (rel) begin
         state_n = IDLE;
         ptr_n   = O_GRANT_IDX + 4'd1;
         to_n    = rel_c && !rel_a && !rel_b;
`ifdef ARB_BACK_TO_BACK_EN
         if (|(I_REQ & ~(16'(1) << O_GRANT_IDX))) begin
            state_n = GRANTED;
            idx_n   = pick(I_REQ & ~(16'(1) << O_GRANT_IDX), O_GRANT_IDX + 4'd1);
            cnt_n   = 8'd0;
         end
`endif
      end else begin
         cnt_n = cnt + {7'd0, cnt != 8'hFF};
      end
   end

   // State, pointer, grant index, hold counter and timeout pulse registers.
   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         state       <= IDLE;
         ptr         <= 4'd0;
         O_GRANT_IDX <= 4'd0;
         cnt         <= 8'd0;
         O_TIMEOUT   <= 1'b0;
      end else begin
         state       <= state_n;
         ptr         <= ptr_n;
         O_GRANT_IDX <= idx_n;
         cnt         <= cnt_n;
         O_TIMEOUT   <= to_n;
      end
   end

   assign O_GRANT_VALID = state == GRANTED;

   decoder4_16 u_dec (
      .idx (O_GRANT_IDX),
      .en  (O_GRANT_VALID),
      .y   (O_GRANT)
   );
endmodule

// File: tb/tb_arbiter_rr16.sv
// tb_arbiter_rr16: directed vector table plus timeout and async-reset sequences for arbiter_rr16.
module tb_arbiter_rr16;
   logic        I_CLK = 1'b0;
   logic        I_RESET = 1'b1;
   logic [15:0] I_REQ = 16'h0000;
   logic        I_RELEASE = 1'b0;
   logic [15:0] O_GRANT;
   logic [3:0]  O_GRANT_IDX;
   logic        O_GRANT_VALID;
   logic        O_TIMEOUT;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [15:0] req;
      logic        rel;
      logic        v;
      logic [3:0]  idx;
      logic        to;
   } vec_t;

   vec_t vt[25];

   arbiter_rr16 #(.MAX_HOLD(8)) dut (
      .I_CLK         (I_CLK),
      .I_RESET       (I_RESET),
      .I_REQ         (I_REQ),
      .I_RELEASE     (I_RELEASE),
      .O_GRANT       (O_GRANT),
      .O_GRANT_IDX   (O_GRANT_IDX),
      .O_GRANT_VALID (O_GRANT_VALID),
      .O_TIMEOUT     (O_TIMEOUT)
   );

   always #5 I_CLK = ~I_CLK;

   task automatic check(input string name, input logic v, input logic [3:0] idx, input logic to);
      logic [15:0] g;
      g = v ? 16'(1) << idx : 16'h0000;
      tests++;
      if ({O_GRANT_VALID, O_GRANT_IDX, O_TIMEOUT, O_GRANT} !== {v, idx, to, g}) begin
         fails++;
         $display("FAIL %s: got valid=%b idx=%0d to=%b grant=%h, want valid=%b idx=%0d to=%b grant=%h",
                  name, O_GRANT_VALID, O_GRANT_IDX, O_TIMEOUT, O_GRANT, v, idx, to, g);
      end
   endtask

   task automatic step(input logic [15:0] req, input logic rel);
      I_REQ = req;
      I_RELEASE = rel;
      @(posedge I_CLK);
      #1;
   endtask

   always @(negedge I_CLK) begin
      tests++;
      if (O_GRANT !== (O_GRANT_VALID ? 16'(1) << O_GRANT_IDX : 16'h0000)) begin
         fails++;
         $display("FAIL onehot: grant=%h valid=%b idx=%0d", O_GRANT, O_GRANT_VALID, O_GRANT_IDX);
      end
   end

   initial begin
      vt[0]  = '{16'h0001, 1'b0, 1'b1, 4'd0,  1'b0};
      vt[1]  = '{16'h0001, 1'b1, 1'b0, 4'd0,  1'b0};
      vt[2]  = '{16'h0000, 1'b0, 1'b0, 4'd0,  1'b0};
      vt[3]  = '{16'h0000, 1'b1, 1'b0, 4'd0,  1'b0};
      vt[4]  = '{16'h8005, 1'b0, 1'b1, 4'd2,  1'b0};
      vt[5]  = '{16'h8005, 1'b1, 1'b0, 4'd2,  1'b0};
      vt[6]  = '{16'h8005, 1'b0, 1'b1, 4'd15, 1'b0};
      vt[7]  = '{16'h8005, 1'b1, 1'b0, 4'd15, 1'b0};
      vt[8]  = '{16'h8005, 1'b0, 1'b1, 4'd0,  1'b0};
      vt[9]  = '{16'h8005, 1'b1, 1'b0, 4'd0,  1'b0};
      vt[10] = '{16'h8005, 1'b0, 1'b1, 4'd2,  1'b0};
      vt[11] = '{16'h8005, 1'b1, 1'b0, 4'd2,  1'b0};
      vt[12] = '{16'h8000, 1'b0, 1'b1, 4'd15, 1'b0};
      vt[13] = '{16'h8000, 1'b1, 1'b0, 4'd15, 1'b0};
      vt[14] = '{16'h8001, 1'b0, 1'b1, 4'd0,  1'b0};
      vt[15] = '{16'h8001, 1'b1, 1'b0, 4'd0,  1'b0};
      vt[16] = '{16'h0008, 1'b0, 1'b1, 4'd3,  1'b0};
      vt[17] = '{16'h0000, 1'b0, 1'b0, 4'd3,  1'b0};
      vt[18] = '{16'h0030, 1'b0, 1'b1, 4'd4,  1'b0};
      vt[19] = '{16'h0032, 1'b0, 1'b1, 4'd4,  1'b0};
      vt[20] = '{16'h0032, 1'b1, 1'b0, 4'd4,  1'b0};
      vt[21] = '{16'h0032, 1'b0, 1'b1, 4'd5,  1'b0};
      vt[22] = '{16'h0032, 1'b1, 1'b0, 4'd5,  1'b0};
      vt[23] = '{16'h0032, 1'b0, 1'b1, 4'd1,  1'b0};
      vt[24] = '{16'h0000, 1'b0, 1'b0, 4'd1,  1'b0};

      #1;
      check("reset", 1'b0, 4'd0, 1'b0);
      #20;
      I_RESET = 1'b0;

      for (int i = 0; i < 25; i++) begin
         step(vt[i].req, vt[i].rel);
         check($sformatf("vec%0d", i), vt[i].v, vt[i].idx, vt[i].to);
      end

      // Timeout: pointer is 2, so 0x0010 grants idx 4 for exactly 8 cycles.
      for (int i = 0; i < 8; i++) begin
         step(16'h0010, 1'b0);
         check($sformatf("hold%0d", i), 1'b1, 4'd4, 1'b0);
      end
      step(16'h0010, 1'b0);
      check("timeout_pulse", 1'b0, 4'd4, 1'b1);
      step(16'h0000, 1'b0);
      check("timeout_clear", 1'b0, 4'd4, 1'b0);

      // Release coinciding with the timeout edge is a normal release.
      for (int i = 0; i < 8; i++) begin
         step(16'h0010, 1'b0);
         check($sformatf("hold_rel%0d", i), 1'b1, 4'd4, 1'b0);
      end
      step(16'h0010, 1'b1);
      check("rel_at_limit", 1'b0, 4'd4, 1'b0);
      step(16'h0000, 1'b0);
      check("rel_at_limit_after", 1'b0, 4'd4, 1'b0);

      // Async reset mid-grant with pointer at 5; afterwards 0x0081 must pick idx 0.
      step(16'h0080, 1'b0);
      check("grant7", 1'b1, 4'd7, 1'b0);
      #2;
      I_RESET = 1'b1;
      #1;
      check("async_reset", 1'b0, 4'd0, 1'b0);
      @(negedge I_CLK);
      #2;
      I_RESET = 1'b0;
      step(16'h0081, 1'b0);
      check("ptr_reset", 1'b1, 4'd0, 1'b0);
      step(16'h0081, 1'b1);
      check("ptr_reset_rel", 1'b0, 4'd0, 1'b0);
      step(16'h0081, 1'b0);
      check("after_reset_rr", 1'b1, 4'd7, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
